radix2_divider: RTL

Multi-cycle 32-bit integer divider presenting AXI4-Stream-style dividend/divisor slave channels and a dout master channel. It is the responder that a divide functional unit drives: operands are accepted together, quotient and remainder are returned as one 64-bit beat. It executes restoring radix-2 division, one quotient bit per cycle, with data-independent latency.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_restoring_step.sv | 33 +++
 rtl/radix2_divider.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the radix-2 restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient returned when the divisor is zero
    localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUOT = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_restoring_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_restoring_step
//  Description : One restoring-division iteration. Shifts the next dividend
//                bit into the partial remainder and trial-subtracts the
//                divisor; the difference is kept only when no borrow occurs.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_unused_diff_msb;

    // Trial subtract on WIDTH+2 bits so the borrow lands in the top bit
    assign w_shifted = {rem_in, dvd_msb};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, divisor};
    assign q_bit     = ~w_diff[WIDTH+1];

    // With the invariant rem_in < divisor the kept value always fits WIDTH bits
    assign rem_out           = q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_unused_diff_msb = w_diff[WIDTH];

endmodule : div_restoring_step
`default_nettype wire

// File: rtl/radix2_divider.sv
`default_nettype none
// ============================================================================
//  Module      : radix2_divider
//  Description : Multi-cycle restoring radix-2 divider, one quotient bit per
//                cycle, fixed 32-cycle latency. Returns {quotient, remainder}
//                as a single beat with a divide-by-zero flag.
//                Define RADIX2_DIVIDER_SIGNED_EN for two's-complement operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module radix2_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_axis_dividend_tvalid,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    output logic               s_axis_dividend_tready,
    input  logic               s_axis_divisor_tvalid,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    output logic               s_axis_divisor_tready,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_dbz
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_dbz_quot = {WIDTH{1'b1}};

    div_state_t          r_state;
    logic [c_cnt_w-1:0]  r_count;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_dvd;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]    r_dsr;
    logic [WIDTH-1:0]    r_dvd_orig;
    logic                r_tready;
    logic                r_tvalid;
    logic [2*WIDTH-1:0]  r_tdata;
    logic                r_dbz;

    logic [WIDTH-1:0]    w_dvd_mag;
    logic [WIDTH-1:0]    w_dsr_mag;
    logic [WIDTH-1:0]    w_rem_out;
    logic                w_q_bit;
    logic [WIDTH-1:0]    w_quot_fin;
    logic [WIDTH-1:0]    w_rem_fin;
    logic                w_accept;

`ifdef RADIX2_DIVIDER_SIGNED_EN
    logic                r_neg_q;
    logic                r_neg_r;
    logic                w_dvd_neg;
    logic                w_dsr_neg;
`endif

    assign w_accept = s_axis_dividend_tvalid & s_axis_divisor_tvalid;

    div_restoring_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem_in  (r_rem),
        .dvd_msb (r_dvd[WIDTH-1]),
        .divisor (r_dsr),
        .rem_out (w_rem_out),
        .q_bit   (w_q_bit)
    );

    // Operand magnitudes presented to the iterative core
    always_comb begin
`ifdef RADIX2_DIVIDER_SIGNED_EN
        w_dvd_neg = s_axis_dividend_tdata[WIDTH-1];
        w_dsr_neg = s_axis_divisor_tdata[WIDTH-1];
        w_dvd_mag = w_dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
        w_dsr_mag = w_dsr_neg ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;
`else
        w_dvd_mag = s_axis_dividend_tdata;
        w_dsr_mag = s_axis_divisor_tdata;
`endif
    end

    // Final result from the last iteration, sign-corrected where enabled
    always_comb begin
        w_quot_fin = {r_dvd[WIDTH-2:0], w_q_bit};
        w_rem_fin  = w_rem_out;
`ifdef RADIX2_DIVIDER_SIGNED_EN
        if (r_neg_q) w_quot_fin = -{r_dvd[WIDTH-2:0], w_q_bit};
        if (r_neg_r) w_rem_fin  = -w_rem_out;
`endif
    end

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_dvd_orig <= '0;
            r_tready   <= 1'b1;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_dbz      <= 1'b0;
`ifdef RADIX2_DIVIDER_SIGNED_EN
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dvd      <= w_dvd_mag;
                        r_dsr      <= w_dsr_mag;
                        r_dvd_orig <= s_axis_dividend_tdata;
                        r_rem      <= '0;
                        r_count    <= '0;
                        r_tready   <= 1'b0;
                        r_state    <= BUSY;
`ifdef RADIX2_DIVIDER_SIGNED_EN
                        r_neg_q    <= w_dvd_neg ^ w_dsr_neg;
                        r_neg_r    <= w_dvd_neg;
`endif
                    end
                end
                BUSY: begin
                    r_rem   <= w_rem_out;
                    r_dvd   <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last) begin
                        r_tvalid <= 1'b1;
                        r_state  <= DONE;
                        // A zero divisor still runs all iterations; only the result is overridden
                        if (r_dsr == '0) begin
                            r_tdata <= {c_dbz_quot, r_dvd_orig};
                            r_dbz   <= 1'b1;
                        end else begin
                            r_tdata <= {w_quot_fin, w_rem_fin};
                            r_dbz   <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_tvalid <= 1'b0;
                    r_tready <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_tvalid <= 1'b0;
                    r_tready <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign s_axis_dividend_tready = r_tready;
    assign s_axis_divisor_tready  = r_tready;
    assign m_axis_dout_tvalid     = r_tvalid;
    assign m_axis_dout_tdata      = r_tdata;
    assign m_axis_dout_dbz        = r_dbz;

endmodule : radix2_divider
`default_nettype wire
